// File: rtl/conv_pixel_feeder_pkg.sv
// Shared convolution definitions: feeder FSM encoding and frame-size helpers
// used by the pixel feeder and the window line buffer counters.
package conv_pixel_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } feeder_state_t;

    function automatic int pix_per_ch(input int width_img);
        return width_img * width_img;
    endfunction

    function automatic int total_pix(input int width_img, input int num_ch);
        return width_img * width_img * num_ch;
    endfunction

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/feeder_addr_gen.sv
// Read address, pixel and channel counters for the pixel feeder; advances
// once per issued read and flags the last pixel of each channel.
module feeder_addr_gen
    import conv_pixel_feeder_pkg::*;
#(
    parameter int WIDTH_IMG  = 28,
    parameter int NUM_CH     = 1,
    parameter int ADDR_WIDTH = 10,
    parameter int BASE_ADDR  = 0,
    localparam int CH_W      = cnt_w(NUM_CH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  issue,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [CH_W-1:0]       ch_cnt,
    output logic                  wrap,
    output logic                  last_ch
);
    localparam int PPC   = pix_per_ch(WIDTH_IMG);
    localparam int PIX_W = cnt_w(PPC);

    logic [PIX_W-1:0] pix_cnt;

    assign wrap    = (pix_cnt == PIX_W'(PPC - 1));
    assign last_ch = (ch_cnt == CH_W'(NUM_CH - 1));

    // Channels sit back-to-back in RAM, so the address never jumps on a wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr <= ADDR_WIDTH'(BASE_ADDR);
            pix_cnt  <= '0;
            ch_cnt   <= '0;
        end else if (clear) begin
            mem_addr <= ADDR_WIDTH'(BASE_ADDR);
            pix_cnt  <= '0;
            ch_cnt   <= '0;
        end else if (issue) begin
            mem_addr <= mem_addr + ADDR_WIDTH'(1);
            if (wrap) begin
                pix_cnt <= '0;
                if (!last_ch)
                    ch_cnt <= ch_cnt + CH_W'(1);
            end else begin
                pix_cnt <= pix_cnt + PIX_W'(1);
            end
        end
    end

endmodule

// File: rtl/conv_pixel_feeder.sv
// Streams one or more square feature maps from a synchronous-read RAM in
// raster order into the 3x3 window line buffer, one frame per start pulse.
module conv_pixel_feeder
    import conv_pixel_feeder_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int WIDTH_IMG  = 28,
    parameter int NUM_CH     = 1,
    parameter int ADDR_WIDTH = 10,
    parameter int BASE_ADDR  = 0,
    localparam int CH_W      = cnt_w(NUM_CH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  enable,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  last_out,
    output logic [CH_W-1:0]       ch_idx,
    output logic                  busy,
    output logic                  done
);
    feeder_state_t   state_q, state_d;
    logic            clear, wrap, last_ch;
    logic [CH_W-1:0] ch_cnt;

    feeder_addr_gen #(
        .WIDTH_IMG  (WIDTH_IMG),
        .NUM_CH     (NUM_CH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .BASE_ADDR  (BASE_ADDR)
    ) u_addr_gen (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .issue    (mem_rd_en),
        .mem_addr (mem_addr),
        .ch_cnt   (ch_cnt),
        .wrap     (wrap),
        .last_ch  (last_ch)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        mem_rd_en = 1'b0;
        clear     = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                clear   = 1'b1;
            end
            RUN: begin
                mem_rd_en = enable;
                if (enable && wrap && last_ch)
                    state_d = DRAIN;
            end
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy     = (state_q == RUN) || (state_q == DRAIN);
    assign done     = (state_q == DONE);
    assign data_out = mem_rdata;

    // Sideband tracks the RAM's one-cycle read latency so it lines up with data_out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_out <= 1'b0;
            last_out  <= 1'b0;
            ch_idx    <= '0;
        end else begin
            valid_out <= mem_rd_en;
            last_out  <= mem_rd_en && wrap;
            if (mem_rd_en)
                ch_idx <= ch_cnt;
        end
    end

endmodule

// File: tb/tb_conv_pixel_feeder.sv
// Directed bench for conv_pixel_feeder: single- and dual-channel frames,
// stalls, ignored starts, mid-frame reset and back-to-back frames.
module tb_conv_pixel_feeder;
    localparam int DW = 16;
    localparam int AW = 6;

    logic          clk, reset;
    logic          a_start, a_en, a_rd, a_valid, a_last, a_busy, a_done;
    logic [0:0]    a_ch;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_rdata, a_data;
    logic          b_start, b_en, b_rd, b_valid, b_last, b_busy, b_done;
    logic [0:0]    b_ch;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_rdata, b_data;

    int n_vec, n_err;

    conv_pixel_feeder #(.DATA_WIDTH(DW), .WIDTH_IMG(4), .NUM_CH(1), .ADDR_WIDTH(AW), .BASE_ADDR(0)) dut_a (
        .clk(clk), .reset(reset), .start(a_start), .enable(a_en), .mem_rd_en(a_rd), .mem_addr(a_addr),
        .mem_rdata(a_rdata), .data_out(a_data), .valid_out(a_valid), .last_out(a_last), .ch_idx(a_ch),
        .busy(a_busy), .done(a_done));

    conv_pixel_feeder #(.DATA_WIDTH(DW), .WIDTH_IMG(4), .NUM_CH(2), .ADDR_WIDTH(AW), .BASE_ADDR(8)) dut_b (
        .clk(clk), .reset(reset), .start(b_start), .enable(b_en), .mem_rd_en(b_rd), .mem_addr(b_addr),
        .mem_rdata(b_rdata), .data_out(b_data), .valid_out(b_valid), .last_out(b_last), .ch_idx(b_ch),
        .busy(b_busy), .done(b_done));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAMs holding RAM[i] = i.
    always @(posedge clk) if (a_rd) a_rdata <= DW'(a_addr);
    always @(posedge clk) if (b_rd) b_rdata <= DW'(b_addr);

    task automatic test_reset;
        n_vec++; if ({a_rd, a_valid, a_last, a_busy, a_done} !== 5'b0) begin n_err++;
            $display("FAIL reset_a_outputs: got rd/valid/last/busy/done=%b want 00000", {a_rd, a_valid, a_last, a_busy, a_done}); end
        n_vec++; if ({b_rd, b_valid, b_last, b_busy, b_done} !== 5'b0) begin n_err++;
            $display("FAIL reset_b_outputs: got %b want 00000", {b_rd, b_valid, b_last, b_busy, b_done}); end
        n_vec++; if (a_addr !== 6'd0 || a_ch !== 1'b0) begin n_err++;
            $display("FAIL reset_a_addr: got addr=%0d ch=%0d want 0 0", a_addr, a_ch); end
        n_vec++; if (b_addr !== 6'd8 || b_ch !== 1'b0) begin n_err++;
            $display("FAIL reset_b_addr: got addr=%0d ch=%0d want 8 0", b_addr, b_ch); end
    endtask

    // Start at c=0: RUN c=1..16, data c-2 on c=2..17, done at c=18.
    task automatic test_stream(input string tag);
        logic ev;
        a_start = 1'b1; a_en = 1'b1;
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            if (c == 1) a_start = 1'b0;
            ev = (c >= 2 && c <= 17);
            n_vec++; if (a_valid !== ev) begin n_err++;
                $display("FAIL %s_valid c=%0d: got %b want %b", tag, c, a_valid, ev); end
            if (ev) begin
                n_vec++; if (a_data !== DW'(c - 2) || a_last !== (c == 17)) begin n_err++;
                    $display("FAIL %s_data c=%0d: got %0d last=%b want %0d last=%b", tag, c, a_data, a_last, c - 2, c == 17); end
            end
            n_vec++; if (a_done !== (c == 18)) begin n_err++;
                $display("FAIL %s_done c=%0d: got %b want %b", tag, c, a_done, c == 18); end
            n_vec++; if (a_busy !== (c <= 17)) begin n_err++;
                $display("FAIL %s_busy c=%0d: got %b want %b", tag, c, a_busy, c <= 17); end
        end
    endtask

    task automatic test_multi_channel;
        logic ev;
        b_start = 1'b1; b_en = 1'b1;
        for (int c = 1; c <= 38; c++) begin
            @(negedge clk);
            if (c == 1) b_start = 1'b0;
            ev = (c >= 2 && c <= 33);
            n_vec++; if (b_valid !== ev) begin n_err++;
                $display("FAIL multi_valid c=%0d: got %b want %b", c, b_valid, ev); end
            if (ev) begin
                n_vec++; if (b_data !== DW'(c + 6) || b_last !== (c == 17 || c == 33) || b_ch !== 1'(c >= 18)) begin n_err++;
                    $display("FAIL multi_data c=%0d: got %0d last=%b ch=%0d want %0d last=%b ch=%0d",
                             c, b_data, b_last, b_ch, c + 6, (c == 17 || c == 33), c >= 18); end
            end
            n_vec++; if (b_done !== (c == 34)) begin n_err++;
                $display("FAIL multi_done c=%0d: got %b want %b", c, b_done, c == 34); end
        end
    endtask

    task automatic test_stall;
        logic [3:0]    pat = 4'b1001;
        logic          prev_en, prev_busy;
        logic [AW-1:0] prev_addr;
        int exp = 0, n_done = 0, n_last = 0;
        a_start = 1'b1; a_en = pat[3];
        prev_busy = 1'b0; prev_addr = a_addr;
        for (int c = 1; c <= 80 && n_done == 0; c++) begin
            @(negedge clk);
            a_start = 1'b0;
            prev_en = a_en;
            if (a_valid) begin
                n_vec++; if (!prev_en) begin n_err++;
                    $display("FAIL stall_bubble c=%0d: got valid=1 want 0 after enable=0", c); end
                n_vec++; if (a_data !== DW'(exp) || a_last !== (exp == 15)) begin n_err++;
                    $display("FAIL stall_data c=%0d: got %0d last=%b want %0d last=%b", c, a_data, a_last, exp, exp == 15); end
                exp++;
                if (a_last) n_last++;
            end
            if (prev_busy && !prev_en) begin
                n_vec++; if (a_addr !== prev_addr) begin n_err++;
                    $display("FAIL stall_addr c=%0d: got %0d want %0d", c, a_addr, prev_addr); end
            end
            if (a_done) n_done++;
            prev_busy = a_busy; prev_addr = a_addr;
            a_en = pat[3 - (c % 4)];
        end
        n_vec++; if (exp != 16 || n_done != 1 || n_last != 1) begin n_err++;
            $display("FAIL stall_totals: got pixels=%0d done=%0d last=%0d want 16 1 1", exp, n_done, n_last); end
        a_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_start_ignored;
        logic ev;
        a_start = 1'b1; a_en = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            ev = (c >= 2 && c <= 17);
            n_vec++; if (a_valid !== ev || (ev && a_data !== DW'(c - 2))) begin n_err++;
                $display("FAIL ignore_stream c=%0d: got valid=%b data=%0d want valid=%b data=%0d", c, a_valid, a_data, ev, c - 2); end
            n_vec++; if (a_busy !== (c <= 17) || a_done !== (c == 18)) begin n_err++;
                $display("FAIL ignore_ctrl c=%0d: got busy=%b done=%b want %b %b", c, a_busy, a_done, c <= 17, c == 18); end
            a_start = (c == 7 || c == 18);
        end
        a_start = 1'b0;
        test_stream("restart");
    endtask

    task automatic test_reset_mid_frame;
        a_start = 1'b1; a_en = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            a_start = 1'b0;
        end
        n_vec++; if (a_valid !== 1'b1 || a_data !== DW'(7)) begin n_err++;
            $display("FAIL midreset_pre: got valid=%b data=%0d want 1 7", a_valid, a_data); end
        reset = 1'b1;
        #1;
        n_vec++; if ({a_rd, a_valid, a_last, a_busy, a_done} !== 5'b0 || a_addr !== 6'd0) begin n_err++;
            $display("FAIL midreset_async: got rd/valid/last/busy/done=%b addr=%0d want 00000 0",
                     {a_rd, a_valid, a_last, a_busy, a_done}, a_addr); end
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_vec++; if (a_valid !== 1'b0 || a_done !== 1'b0 || a_busy !== 1'b0) begin n_err++;
                $display("FAIL midreset_quiet c=%0d: got valid=%b done=%b busy=%b want 0 0 0", c, a_valid, a_done, a_busy); end
        end
        test_stream("after_reset");
    endtask

    // start held high: frame period 19 cycles (RUN 16, DRAIN, DONE, IDLE).
    task automatic test_back_to_back;
        int p;
        logic ev;
        a_start = 1'b1; a_en = 1'b1;
        for (int c = 1; c <= 56; c++) begin
            @(negedge clk);
            p = (c - 1) % 19;
            ev = (p >= 1 && p <= 16);
            n_vec++; if (a_valid !== ev || (ev && a_data !== DW'(p - 1))) begin n_err++;
                $display("FAIL b2b_stream c=%0d: got valid=%b data=%0d want valid=%b data=%0d", c, a_valid, a_data, ev, p - 1); end
            n_vec++; if (a_busy !== (p <= 16) || a_done !== (p == 17)) begin n_err++;
                $display("FAIL b2b_ctrl c=%0d: got busy=%b done=%b want %b %b", c, a_busy, a_done, p <= 16, p == 17); end
        end
        a_start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_vec++; if (a_busy !== 1'b0 || a_valid !== 1'b0) begin n_err++;
                $display("FAIL b2b_idle c=%0d: got busy=%b valid=%b want 0 0", c, a_busy, a_valid); end
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        reset = 1'b1;
        a_start = 1'b0; a_en = 1'b0; b_start = 1'b0; b_en = 1'b0;
        @(negedge clk);
        test_reset;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        test_stream("basic");
        test_multi_channel;
        test_stall;
        test_start_ignored;
        test_reset_mid_frame;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
